sirv_aon_keyed_regwr: RTL and testbench

SIRV_AON_KEYED_REGWR -- requirements
Module: sirv_aon_keyed_regwr

---
 rtl/sirv_aon_keyed_regwr.sv | 125 ++++++++++++
 tb/tb_sirv_aon_keyed_regwr.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sirv_aon_keyed_regwr.sv
// Key-protected write port for an always-on register vector.
// A correct key write opens a TMO-cycle window for exactly one data-register write.
module sirv_aon_keyed_regwr #(
    parameter logic [31:0] KEY = 32'h0051F15E,
    parameter int unsigned TMO = 64,
    parameter int unsigned DW  = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_read,
    input  logic          cmd_addr,
    input  logic [31:0]   cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic [DW-1:0] regvec_d,
    output logic          regvec_en,
    input  logic [DW-1:0] regvec_q,
    output logic          unlocked
);

    localparam int unsigned CW = $clog2(TMO);
    localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t        r_state;
    logic [31:0]   r_rsp_rdata;
    logic          r_rsp_err;
    logic [DW-1:0] r_regvec_d;
    logic          r_regvec_en;
    logic          r_unlocked;
    logic [CW-1:0] r_cnt;

    logic          w_accept;
    logic          w_key_wr;
    logic          w_key_ok;
    logic          w_data_wr;
    logic          w_data_ok;
    logic          w_cnt_last;
    logic          w_err;
    logic [31:0]   w_rd_data;

    // Command decode, all evaluated in the accept cycle
    assign w_accept   = cmd_valid & (r_state == ST_IDLE);
    assign w_key_wr   = w_accept & ~cmd_read & ~cmd_addr;
    assign w_key_ok   = w_key_wr & (cmd_wdata == KEY);
    assign w_data_wr  = w_accept & ~cmd_read & cmd_addr;
    assign w_data_ok  = w_data_wr & r_unlocked;
    assign w_cnt_last = (r_cnt == CNT_LAST);
    assign w_err      = (w_key_wr & ~w_key_ok) | (w_data_wr & ~r_unlocked);
    assign w_rd_data  = cmd_addr ? 32'(regvec_q) : {31'b0, r_unlocked};

    // Request/response handshake FSM with registered response payload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state     <= ST_RESP;
                        r_rsp_rdata <= cmd_read ? w_rd_data : 32'h0;
                        r_rsp_err   <= w_err;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Unlock window, timeout counter and the one-shot register write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_unlocked  <= 1'b0;
            r_cnt       <= '0;
            r_regvec_en <= 1'b0;
            r_regvec_d  <= '0;
        end else begin
            r_regvec_en <= 1'b0;
            if (w_key_ok) begin
                r_unlocked <= 1'b1;
                r_cnt      <= '0;
            end else if (w_key_wr) begin
                r_unlocked <= 1'b0;
                r_cnt      <= '0;
            end else if (w_data_ok) begin
                // Write succeeds even on the last window cycle; it also consumes the unlock
                r_unlocked  <= 1'b0;
                r_cnt       <= '0;
                r_regvec_en <= 1'b1;
                r_regvec_d  <= cmd_wdata[DW-1:0];
            end else if (r_unlocked) begin
                if (w_cnt_last) begin
                    r_unlocked <= 1'b0;
                    r_cnt      <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign regvec_d  = r_regvec_d;
    assign regvec_en = r_regvec_en;
    assign unlocked  = r_unlocked;

endmodule

// File: tb/tb_sirv_aon_keyed_regwr.sv
// Directed scoreboard bench for sirv_aon_keyed_regwr: key/unlock, timeout edges,
// response back-pressure and reset abort, with a behavioural register vector.
module tb_sirv_aon_keyed_regwr;

    localparam int unsigned TMO = 16;
    localparam int unsigned DW  = 20;
    localparam logic [31:0] KEY = 32'h0051F15E;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_read;
    logic          cmd_addr;
    logic [31:0]   cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [DW-1:0] regvec_d;
    logic          regvec_en;
    logic [DW-1:0] regvec_q;
    logic          unlocked;

    exp_t exp_q[$];
    int   n_pass;
    int   n_total;
    int   exp_en_cnt;
    int   en_seen;

    sirv_aon_keyed_regwr #(.KEY(KEY), .TMO(TMO), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_read  (cmd_read),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .regvec_d  (regvec_d),
        .regvec_en (regvec_en),
        .regvec_q  (regvec_q),
        .unlocked  (unlocked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Async-reset register vector fed by the DUT's write port
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) regvec_q <= '0;
        else if (regvec_en) regvec_q <= regvec_d;
    end

    always @(posedge clk) begin
        if (rst_n && regvec_en) en_seen <= en_seen + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One full command/response transaction; returns on the negedge after the handshake
    task automatic do_cmd(input string tag, input logic rd, input logic addr,
                          input logic [31:0] wd, input logic [31:0] exp_rdata,
                          input logic exp_err, input logic exp_en, input int hold);
        exp_t e;
        int   waited;
        logic [DW-1:0] wd_lo;
        wd_lo = wd[DW-1:0];
        @(negedge clk);
        check({tag, ".cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_read  = rd;
        cmd_addr  = addr;
        cmd_wdata = wd;
        exp_q.push_back('{rdata: exp_rdata, err: exp_err});
        if (exp_en) exp_en_cnt++;
        @(negedge clk);
        cmd_valid = 1'b0;
        check({tag, ".rsp_latency"}, 32'(rsp_valid), 32'd1);
        check({tag, ".cmd_ready_busy"}, 32'(cmd_ready), 32'd0);
        check({tag, ".regvec_en"}, 32'(regvec_en), 32'(exp_en));
        if (exp_en) check({tag, ".regvec_d"}, 32'(regvec_d), 32'(wd_lo));
        waited = 0;
        while (!rsp_valid && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        if (!rsp_valid) check({tag, ".rsp_timeout"}, 32'(rsp_valid), 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, ".hold_rdata"}, rsp_rdata, exp_rdata);
            check({tag, ".hold_err"}, 32'(rsp_err), 32'(exp_err));
            check({tag, ".hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
            check({tag, ".hold_en"}, 32'(regvec_en), 32'd0);
        end
        rsp_ready = 1'b1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, ".rdata"}, rsp_rdata, e.rdata);
            check({tag, ".err"}, 32'(rsp_err), 32'(e.err));
        end else begin
            check({tag, ".scoreboard_empty"}, 32'd0, 32'd1);
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, ".rsp_done"}, 32'(rsp_valid), 32'd0);
        check({tag, ".cmd_ready_back"}, 32'(cmd_ready), 32'd1);
        check({tag, ".en_one_cycle"}, 32'(regvec_en), 32'd0);
    endtask

    initial begin
        n_pass     = 0;
        n_total    = 0;
        exp_en_cnt = 0;
        en_seen    = 0;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_read   = 1'b0;
        cmd_addr   = 1'b0;
        cmd_wdata  = 32'h0;
        rsp_ready  = 1'b0;

        // Reset values
        idle(2);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.rsp_rdata", rsp_rdata, 32'h0);
        check("rst.rsp_err", 32'(rsp_err), 32'd0);
        check("rst.regvec_en", 32'(regvec_en), 32'd0);
        check("rst.regvec_d", 32'(regvec_d), 32'h0);
        check("rst.unlocked", 32'(unlocked), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst.cmd_ready_first", 32'(cmd_ready), 32'd1);

        // Unlock then single protected write
        do_cmd("key1", 1'b0, 1'b0, KEY, 32'h0, 1'b0, 1'b0, 0);
        check("key1.unlocked", 32'(unlocked), 32'd1);
        do_cmd("rd_unl", 1'b1, 1'b0, 32'h0, 32'h1, 1'b0, 1'b0, 0);
        check("rd_unl.still_unlocked", 32'(unlocked), 32'd1);
        do_cmd("wr1", 1'b0, 1'b1, 32'h000ABCDE, 32'h0, 1'b0, 1'b1, 0);
        check("wr1.relocked", 32'(unlocked), 32'd0);
        do_cmd("rd1", 1'b1, 1'b1, 32'h0, 32'h000ABCDE, 1'b0, 1'b0, 0);
        do_cmd("rd_lock", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 0);

        // No key, then bad key
        do_cmd("wr_nokey", 1'b0, 1'b1, 32'h00012345, 32'h0, 1'b1, 1'b0, 0);
        do_cmd("badkey", 1'b0, 1'b0, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0, 0);
        check("badkey.unlocked", 32'(unlocked), 32'd0);
        do_cmd("key2", 1'b0, 1'b0, KEY, 32'h0, 1'b0, 1'b0, 0);
        do_cmd("badkey2", 1'b0, 1'b0, KEY ^ 32'h1, 32'h0, 1'b1, 1'b0, 0);
        check("badkey2.unlocked", 32'(unlocked), 32'd0);
        do_cmd("wr_after_bad", 1'b0, 1'b1, 32'h00011111, 32'h0, 1'b1, 1'b0, 0);

        // Window expires just before the write
        do_cmd("key3", 1'b0, 1'b0, KEY, 32'h0, 1'b0, 1'b0, 0);
        idle(TMO - 3);
        check("tmo.unlocked_cnt_m2", 32'(unlocked), 32'd1);
        idle(1);
        check("tmo.unlocked_cnt_last", 32'(unlocked), 32'd1);
        idle(1);
        check("tmo.expired", 32'(unlocked), 32'd0);
        do_cmd("wr_late", 1'b0, 1'b1, 32'h00022222, 32'h0, 1'b1, 1'b0, 0);

        // Write accepted on the last window cycle succeeds; upper bits dropped
        do_cmd("key4", 1'b0, 1'b0, KEY, 32'h0, 1'b0, 1'b0, 0);
        idle(TMO - 3);
        do_cmd("wr_edge", 1'b0, 1'b1, 32'hABCFFFFF, 32'h0, 1'b0, 1'b1, 0);
        check("wr_edge.relocked", 32'(unlocked), 32'd0);

        // Back-pressured read of the full-scale vector
        do_cmd("rd_hold", 1'b1, 1'b1, 32'h0, 32'h000FFFFF, 1'b0, 1'b0, 5);

        // Re-keying restarts the window
        do_cmd("key5", 1'b0, 1'b0, KEY, 32'h0, 1'b0, 1'b0, 0);
        idle(5);
        do_cmd("key6", 1'b0, 1'b0, KEY, 32'h0, 1'b0, 1'b0, 0);
        idle(TMO - 3);
        do_cmd("wr_rekey", 1'b0, 1'b1, 32'h00055555, 32'h0, 1'b0, 1'b1, 0);
        do_cmd("rd_rekey", 1'b1, 1'b1, 32'h0, 32'h00055555, 1'b0, 1'b0, 2);

        // Reset asserted while a key response is pending
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_read  = 1'b0;
        cmd_addr  = 1'b0;
        cmd_wdata = KEY;
        exp_q.push_back('{rdata: 32'h0, err: 1'b0});
        @(negedge clk);
        cmd_valid = 1'b0;
        check("rstmid.rsp_valid_pre", 32'(rsp_valid), 32'd1);
        check("rstmid.unlocked_pre", 32'(unlocked), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstmid.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstmid.unlocked", 32'(unlocked), 32'd0);
        check("rstmid.regvec_d", 32'(regvec_d), 32'h0);
        check("rstmid.rsp_err", 32'(rsp_err), 32'd0);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rstmid.cmd_ready_first", 32'(cmd_ready), 32'd1);
        do_cmd("wr_post_rst", 1'b0, 1'b1, 32'h00033333, 32'h0, 1'b1, 1'b0, 0);
        idle(2);

        check("end.en_pulses", 32'(en_seen), 32'(exp_en_cnt));
        check("end.scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
